// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply/divide unit serving the mult/div instructions
// of the MIPS datapath. The control unit pulses start with op and the two
// operands, waits for done, then copies hi/lo into the HI/LO registers.
// Results stay on hi/lo until the next completed operation.
//
// Ports
//   clk       system clock, everything changes on the rising edge
//   reset     synchronous active-high reset, highest priority
//   start     request, only looked at while idle
//   op        0 = signed multiply, 1 = signed divide (taken with start)
//   a, b      multiplicand/dividend and multiplier/divisor (taken with start)
//   busy      high while iterating and while applying the sign fix-up
//   done      one-cycle pulse, hi/lo (or div_zero) valid
//   div_zero  one-cycle pulse together with done for a divide by zero
//   hi        multiply: upper product half; divide: remainder
//   lo        multiply: lower product half; divide: quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // ZERO is a one-cycle wait on the divide-by-zero path so that its done
    // pulse lands two edges after the request, with busy kept low.
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        ZERO,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   rem_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] mult_next;
    logic [2*WIDTH-1:0] prod_fixed;

    // Operand magnitudes. The most negative value maps onto itself, which is
    // the correct magnitude once read as an unsigned number.
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    // One restoring-division step: acc holds {remainder, dividend/quotient}.
    // Shift left by one, try subtracting the divisor from the upper half and
    // keep the difference only when it did not borrow; the new quotient bit
    // enters at the bottom as the dividend bits leave at the top.
    assign rem_shift = acc[2*WIDTH-2:WIDTH-1];
    assign div_trial = {1'b0, rem_shift} - {1'b0, mcand[WIDTH-1:0]};
    assign div_next  = div_trial[WIDTH] ? {rem_shift, acc[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // One shift-add multiply step: add the shifted multiplicand whenever the
    // current multiplier bit is set.
    assign mult_next  = acc + (mplier[0] ? mcand : '0);
    assign prod_fixed = neg_res ? -acc : acc;

    // State register; reset wins over any pending operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the status outputs, which are pure functions of
    // the state so that reset immediately clears them.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op && (b == '0)) begin
                        state_next = ZERO;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            ZERO: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                div_zero   = dz;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture magnitudes and signs on acceptance, iterate one bit
    // per RUN cycle, and apply the sign correction into hi/lo in FIX. For a
    // divide the divisor sits in the low half of mcand; for a multiply mcand
    // is the left-shifting multiplicand and mplier the right-shifting
    // multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        op_div  <= op;
                        neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem <= a[WIDTH-1];
                        dz      <= op && (b == '0);
                        if (op) begin
                            acc    <= {{WIDTH{1'b0}}, mag_a};
                            mcand  <= {{WIDTH{1'b0}}, mag_b};
                            mplier <= '0;
                        end else begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, mag_a};
                            mplier <= mag_b;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mult_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        lo <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit (WIDTH = 32). A behavioural model
// predicts, cycle by cycle, when a request is accepted, when done fires and
// what hi/lo must hold, using plain 64-bit signed arithmetic. Directed
// scenarios additionally pin the model with hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   // Reference arithmetic: signed product, or truncating signed division,
   // done in 64 bits so the most-negative / -1 case cannot overflow.
   task automatic refCompute(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                             output logic [W-1:0] rh, output logic [W-1:0] rl,
                             output logic rdz);
      longint sa, sb, p, q, r;
      sa  = longint'($signed(ma));
      sb  = longint'($signed(mb));
      rdz = 1'b0;
      rh  = '0;
      rl  = '0;
      if (!mop) begin
         p  = sa * sb;
         rh = p[63:32];
         rl = p[31:0];
      end else if (mb == '0) begin
         rdz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         rl = q[31:0];
         rh = r[31:0];
      end
   endtask

   // Model state. n is the index of the most recent rising edge; k is the
   // edge that accepted the current request and dEdge the edge after which
   // done is visible. A request is accepted when idle or from two edges
   // after the done edge onwards.
   bit           known  = 1'b0;
   bit           active = 1'b0;
   bit           mDz    = 1'b0;
   int           n      = 0;
   int           k      = 0;
   int           dEdge  = 0;
   logic [W-1:0] curHi  = '0;
   logic [W-1:0] curLo  = '0;
   logic [W-1:0] pHi    = '0;
   logic [W-1:0] pLo    = '0;

   // Compare process: on every falling edge check all outputs against the
   // model, then predict the effect of the coming rising edge from the
   // inputs currently applied.
   always @(negedge clk) begin
      logic expDone, expBusy, expDz;
      logic rdz;
      logic [W-1:0] rh, rl;
      n++;
      if (known) begin
         if (active && n == dEdge && !mDz) begin
            curHi = pHi;
            curLo = pLo;
         end
         expDone = active && (n == dEdge);
         expDz   = expDone && mDz;
         expBusy = active && !mDz && (n >= k) && (n < dEdge);
         checkOutput("busy", W'(busy), W'(expBusy));
         checkOutput("done", W'(done), W'(expDone));
         checkOutput("div_zero", W'(div_zero), W'(expDz));
         checkOutput("hi", hi, curHi);
         checkOutput("lo", lo, curLo);
      end
      if (reset) begin
         known  = 1'b1;
         active = 1'b0;
         curHi  = '0;
         curLo  = '0;
      end else if (known && start && (!active || (n + 1 >= dEdge + 2))) begin
         refCompute(op, a, b, rh, rl, rdz);
         active = 1'b1;
         mDz    = rdz;
         pHi    = rh;
         pLo    = rl;
         k      = n + 1;
         dEdge  = rdz ? k + 1 : k + W + 1;
      end
   end

   // Drive one request for a single cycle; called just after a rising edge
   // and returns just after the edge that sampled it.
   task automatic applyStimulus(input logic sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
      start = 1'b1;
      op    = sop;
      a     = sa;
      b     = sb;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Wait, with a bound, for done; reports how many cycles it took.
   task automatic waitDone(output int cyc);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done", cyc);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pickOperand();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       pickOperand = 32'h8000_0000;
         1:       pickOperand = 32'hFFFF_FFFF;
         2:       pickOperand = 32'h7FFF_FFFF;
         3:       pickOperand = 32'(($urandom_range(0, 40)) - 20);
         default: pickOperand = $urandom;
      endcase
   endfunction

   initial begin
      int c;
      int seen;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_busy", W'(busy), '0);
      checkOutput("reset_hi", hi, '0);
      checkOutput("reset_lo", lo, '0);
      stepCycle();

      $display("[TB] mult 7 * -3");
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
      checkOutput("t1_busy_early", W'(busy), 32'd1);
      waitDone(c);
      checkOutput("t1_latency", W'(c), 32'd33);
      checkOutput("t1_hi", hi, 32'hFFFF_FFFF);
      checkOutput("t1_lo", lo, 32'hFFFF_FFEB);
      checkOutput("t1_dz", W'(div_zero), '0);
      stepCycle();

      $display("[TB] div 5 / 0 keeps hi/lo");
      applyStimulus(1'b1, 32'd5, 32'd0);
      checkOutput("t4_busy", W'(busy), '0);
      waitDone(c);
      checkOutput("t4_latency", W'(c), 32'd1);
      checkOutput("t4_dz", W'(div_zero), 32'd1);
      checkOutput("t4_hi", hi, 32'hFFFF_FFFF);
      checkOutput("t4_lo", lo, 32'hFFFF_FFEB);
      stepCycle();

      $display("[TB] mult min * min");
      applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000);
      waitDone(c);
      checkOutput("t2_hi", hi, 32'h4000_0000);
      checkOutput("t2_lo", lo, 32'h0000_0000);
      stepCycle();

      $display("[TB] div -7 / 2");
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
      waitDone(c);
      checkOutput("t3_latency", W'(c), 32'd33);
      checkOutput("t3_lo", lo, 32'hFFFF_FFFD);
      checkOutput("t3_hi", hi, 32'hFFFF_FFFF);
      stepCycle();

      $display("[TB] div min / -1 then back-to-back mult");
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(c);
      checkOutput("t6_lo", lo, 32'h8000_0000);
      checkOutput("t6_hi", hi, 32'h0000_0000);
      stepCycle();
      applyStimulus(1'b0, 32'd3, 32'd5);
      checkOutput("t6_b2b_busy", W'(busy), 32'd1);
      waitDone(c);
      checkOutput("t6_b2b_latency", W'(c), 32'd33);
      checkOutput("t6_b2b_lo", lo, 32'd15);
      stepCycle();

      $display("[TB] start while busy is ignored, then reset mid-operation");
      applyStimulus(1'b0, 32'h0001_2345, 32'h0000_0777);
      repeat (4) stepCycle();
      start = 1'b1;
      op    = 1'b1;
      a     = 32'd100;
      b     = 32'd3;
      stepCycle();
      start = 1'b0;
      waitDone(c);
      checkOutput("t5_hi", hi, 32'h0000_0000);
      checkOutput("t5_lo", lo, 32'h087E_4813);
      stepCycle();
      applyStimulus(1'b1, 32'd1000, 32'd7);
      repeat (9) stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("t5_rst_busy", W'(busy), '0);
      checkOutput("t5_rst_hi", hi, '0);
      checkOutput("t5_rst_lo", lo, '0);
      seen = 0;
      repeat (40) begin
         stepCycle();
         if (done) seen++;
      end
      checkOutput("t5_no_done", W'(seen), '0);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic rop;
         rop = 1'($urandom_range(0, 1));
         ra  = pickOperand();
         rb  = ($urandom_range(0, 7) == 0) ? '0 : pickOperand();
         applyStimulus(rop, ra, rb);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 20)) begin
               if (done) break;
               stepCycle();
            end
            if (!done) begin
               start = 1'b1;
               op    = 1'($urandom_range(0, 1));
               a     = $urandom;
               b     = $urandom;
               stepCycle();
               start = 1'b0;
            end
         end
         waitDone(c);
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1;
            op    = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
            stepCycle();
            start = 1'b0;
         end else begin
            stepCycle();
         end
         repeat ($urandom_range(0, 2)) stepCycle();
      end
      repeat (3) stepCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
